// File: rtl/captura_numero.sv
// captura_numero: input stage for the 4-bit number decoder.
// Synchronises the raw switches and push-button, debounces the button, and
// latches the switch value once per confirmed press. Values above MAX_VALUE
// raise erro instead of pulsing ready.
//
// state        | meaning
// -------------+---------------------------------------------------------
// OCIOSO       | idle, waiting for the synchronised button to go high
// FILTRA_PRESS | button high, counting stable cycles before accepting it
// CAPTURA      | one cycle: latch sw_s (or flag erro if out of range)
// ESPERA_SOLTA | value taken, waiting for the button to be released
// FILTRA_SOLTA | button low, counting stable cycles before re-arming
module captura_numero #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5,
    parameter int MAX_VALUE       = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] sw,
    input  logic       botao,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       ready,
    output logic       erro,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        OCIOSO,
        FILTRA_PRESS,
        CAPTURA,
        ESPERA_SOLTA,
        FILTRA_SOLTA
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_FIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]      MAX_U   = 32'(MAX_VALUE);

    estado_t          estado;
    estado_t          prox;
    logic             b_m;
    logic             b_s;
    logic [3:0]       sw_m;
    logic [3:0]       sw_s;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             captura;
    logic             valor_ok;

    assign valor_ok = ({28'd0, sw_s} <= MAX_U);
    assign ocupado  = (estado != OCIOSO);

    // Two-flop synchronisers for the asynchronous button and switches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_m  <= 1'b0;
            b_s  <= 1'b0;
            sw_m <= 4'd0;
            sw_s <= 4'd0;
        end else begin
            b_m  <= botao;
            b_s  <= b_m;
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    // Next-state logic plus counter and capture strobes.
    always_comb begin
        prox    = estado;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        captura = 1'b0;
        case (estado)
            OCIOSO: begin
                if (b_s) begin
                    cnt_clr = 1'b1;
                    prox    = FILTRA_PRESS;
                end
            end
            FILTRA_PRESS: begin
                if (!b_s) begin
                    prox = OCIOSO;
                end else if (cnt == CNT_FIM) begin
                    prox = CAPTURA;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            CAPTURA: begin
                captura = 1'b1;
                prox    = ESPERA_SOLTA;
            end
            ESPERA_SOLTA: begin
                if (!b_s) begin
                    cnt_clr = 1'b1;
                    prox    = FILTRA_SOLTA;
                end
            end
            FILTRA_SOLTA: begin
                if (b_s) begin
                    prox = ESPERA_SOLTA;
                end else if (cnt == CNT_FIM) begin
                    prox = OCIOSO;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: prox = OCIOSO;
        endcase
    end

    // Debounce counter; stops at the terminal count because the state
    // moves on there, and is cleared on entry to each filter state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt_inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Registered outputs: value and ready change together, erro is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {A, B, C, D} <= 4'd0;
            ready        <= 1'b0;
            erro         <= 1'b0;
        end else begin
            ready <= captura && valor_ok;
            if (captura) begin
                if (valor_ok) begin
                    {A, B, C, D} <= sw_s;
                    erro         <= 1'b0;
                end else begin
                    erro <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_captura_numero.sv
// tb_captura_numero: directed scenarios plus a randomized button/switch run,
// checked every cycle against a run-length model of the debounced press.
module tb_captura_numero;

    localparam int DB  = 16;
    localparam int MAX = 9;

    logic       clock = 1'b0;
    logic       reset;
    logic       botao;
    logic [3:0] sw;
    logic       A, B, C, D;
    logic       ready, erro, ocupado;

    captura_numero #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_W(5),
        .MAX_VALUE(MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .sw(sw),
        .botao(botao),
        .A(A),
        .B(B),
        .C(C),
        .D(D),
        .ready(ready),
        .erro(erro),
        .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a press is accepted after DB+1 consecutive
    // synchronised-high samples; re-arming needs DB+1 consecutive lows.
    int         m_mode;   // 0 waiting for press, 1 capture edge, 2 waiting for release
    int         m_run;
    int         m_rel;
    logic       m_b1, m_b2;
    logic [3:0] m_s1, m_s2;
    logic [3:0] e_val;
    logic       e_ready, e_erro;

    int cyc = 0;
    int ready_cnt = 0;
    int ready_cyc = 0;
    int press_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_run   = 0;
        m_rel   = 0;
        m_b1    = 1'b0;
        m_b2    = 1'b0;
        m_s1    = 4'd0;
        m_s2    = 4'd0;
        e_val   = 4'd0;
        e_ready = 1'b0;
        e_erro  = 1'b0;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            e_ready = 1'b0;
            case (m_mode)
                0: begin
                    if (m_b2) begin
                        m_run++;
                        if (m_run == DB + 1) m_mode = 1;
                    end else begin
                        m_run = 0;
                    end
                end
                1: begin
                    if (int'(m_s2) <= MAX) begin
                        e_val   = m_s2;
                        e_ready = 1'b1;
                        e_erro  = 1'b0;
                    end else begin
                        e_erro = 1'b1;
                    end
                    m_mode = 2;
                    m_rel  = 0;
                end
                default: begin
                    if (!m_b2) begin
                        m_rel++;
                        if (m_rel == DB + 1) begin
                            m_mode = 0;
                            m_run  = 0;
                        end
                    end else begin
                        m_rel = 0;
                    end
                end
            endcase
            m_b2 = m_b1;
            m_b1 = botao;
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    function automatic logic e_ocupado();
        return (m_mode != 0) || (m_run > 0);
    endfunction

    task automatic check_outputs();
        chk("valor",   {A, B, C, D}, e_val);
        chk("ready",   ready,        e_ready);
        chk("erro",    erro,         e_erro);
        chk("ocupado", ocupado,      e_ocupado());
    endtask

    task automatic step(input logic b, input logic [3:0] s);
        @(negedge clock);
        botao = b;
        sw    = s;
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        check_outputs();
        if (ready === 1'b1) begin
            ready_cnt++;
            ready_cyc = cyc;
        end
    endtask

    task automatic repeat_step(input int n, input logic b, input logic [3:0] s);
        for (int i = 0; i < n; i++) step(b, s);
    endtask

    initial begin
        reset = 1'b0;
        botao = 1'b0;
        sw    = 4'd0;
        model_reset();

        // Asynchronous reset from power-up, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        chk("por_valor",   {A, B, C, D}, 4'd0);
        chk("por_ready",   ready,        1'b0);
        chk("por_erro",    erro,         1'b0);
        chk("por_ocupado", ocupado,      1'b0);
        repeat_step(3, 1'b0, 4'd0);
        reset = 1'b0;
        repeat_step(3, 1'b0, 4'd0);

        // Clean press held for 40 cycles.
        ready_cnt = 0;
        press_cyc = cyc + 1;
        repeat_step(40, 1'b1, 4'b0110);
        chk("clean_pulses",  ready_cnt,             1);
        chk("clean_latency", ready_cyc - press_cyc, DB + 3);
        chk("clean_valor",   {A, B, C, D},          4'b0110);
        repeat_step(25, 1'b0, 4'b0110);

        // Bouncing button, then a steady hold.
        ready_cnt = 0;
        for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0, 4'b0110);
        chk("bounce_none_yet", ready_cnt, 0);
        repeat_step(30, 1'b1, 4'b0110);
        chk("bounce_pulses", ready_cnt,    1);
        chk("bounce_valor",  {A, B, C, D}, 4'b0110);
        repeat_step(25, 1'b0, 4'b0110);

        // Out-of-range value keeps the old value and flags erro.
        ready_cnt = 0;
        repeat_step(30, 1'b1, 4'b1100);
        repeat_step(25, 1'b0, 4'b1100);
        chk("oor_pulses", ready_cnt,    0);
        chk("oor_erro",   erro,         1'b1);
        chk("oor_valor",  {A, B, C, D}, 4'b0110);

        // Valid press clears erro.
        ready_cnt = 0;
        repeat_step(30, 1'b1, 4'b0011);
        repeat_step(25, 1'b0, 4'b0011);
        chk("ok_pulses", ready_cnt,    1);
        chk("ok_erro",   erro,         1'b0);
        chk("ok_valor",  {A, B, C, D}, 4'b0011);

        // Short glitch shorter than the debounce window.
        ready_cnt = 0;
        repeat_step(5, 1'b1, 4'b0101);
        repeat_step(8, 1'b0, 4'b0101);
        chk("glitch_pulses",  ready_cnt, 0);
        chk("glitch_ocupado", ocupado,   1'b0);

        // Reset in the middle of filtering a press.
        ready_cnt = 0;
        repeat_step(8, 1'b1, 4'b0101);
        chk("midf_ocupado", ocupado, 1'b1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_valor",   {A, B, C, D}, 4'd0);
        chk("midrst_ready",   ready,        1'b0);
        chk("midrst_erro",    erro,         1'b0);
        chk("midrst_ocupado", ocupado,      1'b0);
        repeat_step(3, 1'b1, 4'b0101);
        chk("midrst_pulses", ready_cnt, 0);
        reset     = 1'b0;
        press_cyc = cyc + 1;
        repeat_step(30, 1'b1, 4'b0101);
        chk("after_rst_pulses",  ready_cnt,             1);
        chk("after_rst_latency", ready_cyc - press_cyc, DB + 3);
        repeat_step(25, 1'b0, 4'b0101);

        // Randomized button levels with random-length holds; switches
        // change every cycle so only the capture-cycle value matters.
        for (int seg = 0; seg < 60; seg++) begin
            int   len;
            logic lvl;
            lvl = seg[0];
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) step(lvl, 4'($urandom_range(0, 15)));
        end
        repeat_step(25, 1'b0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/captura_numero.md
Name: captura_numero

Overview:
- Upstream input stage for the 4-bit number decoder. It samples four raw switch lines and a raw push-button, synchronises and debounces the button, and latches the switch value once per confirmed press.
- It presents the latched value on A, B, C, D, with A as the MSB, and pulses ready so the decoder updates its display outputs.
- Values above MAX_VALUE are rejected: an error flag is raised and ready is not pulsed.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable clock cycles the synchronised button must hold a level before the level is accepted (minimum 1).
- CNT_W, 5, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- MAX_VALUE, 9, largest accepted 4-bit value; sw values above this are rejected.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- sw  input  4  raw switch value, asynchronous to clock; sw[3] maps to A, sw[0] maps to D.
- botao  input  1  raw push-button, active-high, bouncy, asynchronous.
- A  output  1  latched value bit 3 (MSB).
- B  output  1  latched value bit 2.
- C  output  1  latched value bit 1.
- D  output  1  latched value bit 0 (LSB).
- ready  output  1  one-cycle pulse: a new valid value is on A..D.
- erro  output  1  sticky flag: last press captured an out-of-range value.
- ocupado  output  1  high while the FSM is not in OCIOSO.

Behaviour:
- Reset (asynchronous, active-high) drives all of the following to 0: A, B, C, D, ready, erro, ocupado, the synchroniser flops and the debounce counter. The FSM goes to OCIOSO.
- Deasserting reset takes effect at the next clock edge.
- Reset asserted mid-press aborts the capture: no ready pulse, outputs cleared.
- Synchronisation: botao and sw each pass through 2 flops. Only the synchronised copies, b_s and sw_s, are used internally.
- Capture: sw_s is sampled in the same cycle that the press is confirmed.
- FSM states: OCIOSO, FILTRA_PRESS, CAPTURA, ESPERA_SOLTA, FILTRA_SOLTA.
- OCIOSO:
  - ocupado=0.
  - b_s=1 -> clear counter, go to FILTRA_PRESS.
- FILTRA_PRESS:
  - b_s=1 -> counter increments.
  - b_s=0 -> return to OCIOSO; nothing is captured (this is a glitch).
  - Counter reaches DEBOUNCE_CYCLES-1 with b_s=1 -> go to CAPTURA.
- CAPTURA (exactly one cycle):
  - If sw_s <= MAX_VALUE: {A,B,C,D} <= sw_s, ready <= 1 for the next cycle only, erro <= 0.
  - Otherwise: A..D are held, ready stays 0, erro <= 1.
  - Always go to ESPERA_SOLTA.
- ESPERA_SOLTA:
  - b_s=0 -> clear counter, go to FILTRA_SOLTA.
  - Holding the button indefinitely produces no further captures (no auto-repeat).
- FILTRA_SOLTA:
  - b_s=0 -> counter increments.
  - b_s=1 -> return to ESPERA_SOLTA.
  - Counter reaches DEBOUNCE_CYCLES-1 -> go to OCIOSO.
- Latency: raw press edge to ready high = 2 (sync) + DEBOUNCE_CYCLES + 1 (CAPTURA) + 0 (registered pulse) cycles, i.e. DEBOUNCE_CYCLES+3 cycles after the first clock that sees botao=1.
- Output timing:
  - ready is registered, high for exactly one clock per accepted press.
  - A..D change only in the same cycle that ready rises.
  - erro is held until the next accepted capture or reset.
- sw changes during ESPERA_SOLTA or FILTRA_* are ignored; only the value at the CAPTURA cycle counts.
- The counter never wraps: it saturates conceptually, since leaving the state clears it.
- DEBOUNCE_CYCLES=1: each filter state lasts one cycle.

Test Plan:
- Reset: assert reset mid-cycle with outputs nonzero -> A..D, ready, erro, ocupado all 0 immediately, without waiting for a clock edge.
- Clean press: DEBOUNCE_CYCLES=16, sw=4'b0110, botao held for 40 cycles -> {A,B,C,D}=0110 and ready high for 1 cycle, 19 cycles after botao rises; no second pulse while held.
- Bounce: botao toggles 1/0 every 3 cycles for 30 cycles, then stays at 1 -> exactly one ready pulse, latched value equals sw at capture.
- Out of range: sw=4'b1100, valid press -> erro=1, ready never rises, A..D keep the previous value 0110. A next press with sw=4'b0011 -> erro=0, ready pulse, A..D=0011.
- Glitch: botao high for 5 cycles only (< DEBOUNCE_CYCLES) -> no ready, FSM back in OCIOSO, ocupado returns to 0.
- Reset mid-filter: reset pulsed while in FILTRA_PRESS, botao still held -> no ready during reset; after release, a full debounce from OCIOSO is required before ready.
